uart_tx_fifo: RTL

Byte FIFO between the trace logger's byte stream and the UART transmitter. It decouples logger bursts from UART line rate, so the logger never stalls the core's error-dump path longer than necessary. Both sides use a valid/ready handshake. An optional build feature expands LF into CR LF on the serial line.

---
 rtl/aether_pkg.sv | 27 ++
 rtl/fifo_ram.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/aether_pkg.sv
// -----------------------------------------------------------------------------
// aether_pkg
// Shared definitions for the trace-logger to UART byte path.
//   UART_BYTE_W  : width of one serial byte
//   ASCII_LF/CR  : line-feed and carriage-return codes used by the optional
//                  LF -> CR LF expansion (macro UART_TX_FIFO_CRLF_EN)
//   crlf_state_t : the two beats of an expanded line feed
//   is_lf()      : helper used wherever a byte is classified as a line feed
// -----------------------------------------------------------------------------
package aether_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [UART_BYTE_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [UART_BYTE_W-1:0] ASCII_CR = 8'h0D;

    typedef enum logic [0:0] {
        SEND_CR = 1'b0,
        SEND_LF = 1'b1
    } crlf_state_t;

    // True when the byte is a line feed and would be expanded in CRLF builds.
    function automatic logic is_lf(input logic [UART_BYTE_W-1:0] b);
        return (b == ASCII_LF);
    endfunction

endpackage : aether_pkg

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DEPTH x UART_BYTE_W storage for uart_tx_fifo. One synchronous write port,
// one asynchronous (combinational) read port so the FIFO head is visible in
// the same cycle as the read pointer. The array is intentionally not reset;
// the FIFO pointers decide which entries are meaningful.
// Ports:
//   clk    in   system clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module fifo_ram
    import aether_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_BYTE_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_BYTE_W-1:0] rdata
);

    logic [UART_BYTE_W-1:0] mem_r [DEPTH];

    // Synchronous write port; no reset on the data array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : fifo_ram

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO between logger_uart and uart_peripheral. Absorbs logger bursts so
// the error-dump path is not throttled by the UART line rate. Both sides use
// valid/ready. Show-ahead: the head byte is presented combinationally.
//
// Build option: define UART_TX_FIFO_CRLF_EN to send every stored 0x0A as the
// two beats 0x0D, 0x0A. The injected CR is not stored and not counted in level.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_i      in   asynchronous active-low reset
//   flush      in   synchronous clear; beats any push/pop in the same cycle
//   in_data    in   byte from the logger
//   in_valid   in   in_data valid
//   in_ready   out  a byte can be accepted (not full)
//   out_data   out  byte presented to the UART
//   out_valid  out  out_data valid (not empty)
//   out_ready  in   UART accepts out_data
//   level      out  stored byte count, 0..DEPTH
//
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import aether_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     flush,
    input  logic [UART_BYTE_W-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [UART_BYTE_W-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]            wr_ptr_r;
    logic [AW:0]            rd_ptr_r;

    logic                   empty_s;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   hold_s;      // handshake consumed by an injected beat
    logic [UART_BYTE_W-1:0] head_s;
    logic [UART_BYTE_W-1:0] out_data_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    // in_ready looks only at full: a pop this cycle never frees room for a
    // push in the same cycle, which keeps the ready path free of out_ready.
    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign out_data  = out_data_s;
    assign level     = wr_ptr_r - rd_ptr_r;

    assign push_s = in_valid && !full_s && !flush;
    assign pop_s  = out_valid && out_ready && !hold_s && !flush;

    fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (head_s)
    );

    // Write pointer: advances on every accepted byte, cleared by flush.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= PTR_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
    end

    // Read pointer: advances only when the stored head byte itself is taken.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_r <= PTR_ZERO;
        end else if (flush) begin
            rd_ptr_r <= PTR_ZERO;
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN

    localparam logic [0:0] ST_SEND_CR = 1'b0;
    localparam logic [0:0] ST_SEND_LF = 1'b1;

    logic [0:0] crlf_state_r;
    logic [0:0] crlf_state_nxt_s;
    logic       head_is_lf_s;
    logic       beat_hs_s;

    assign head_is_lf_s = is_lf(head_s);
    assign beat_hs_s    = out_valid && out_ready;

    // Output mux: a line-feed head first shows up as CR and holds the pop.
    always_comb begin
        out_data_s = head_s;
        hold_s     = 1'b0;
        case (crlf_state_r)
            ST_SEND_CR: begin
                if (head_is_lf_s) begin
                    out_data_s = ASCII_CR;
                    hold_s     = 1'b1;
                end else begin
                    out_data_s = head_s;
                    hold_s     = 1'b0;
                end
            end
            ST_SEND_LF: begin
                out_data_s = head_s;
                hold_s     = 1'b0;
            end
            default: begin
                out_data_s = head_s;
                hold_s     = 1'b0;
            end
        endcase
    end

    // Next state: only a line-feed head moves the machine; the LF beat pops
    // it and returns to SEND_CR for the next byte.
    always_comb begin
        crlf_state_nxt_s = crlf_state_r;
        case (crlf_state_r)
            ST_SEND_CR: begin
                if (beat_hs_s && head_is_lf_s) begin
                    crlf_state_nxt_s = ST_SEND_LF;
                end else begin
                    crlf_state_nxt_s = ST_SEND_CR;
                end
            end
            ST_SEND_LF: begin
                if (beat_hs_s) begin
                    crlf_state_nxt_s = ST_SEND_CR;
                end else begin
                    crlf_state_nxt_s = ST_SEND_LF;
                end
            end
            default: begin
                crlf_state_nxt_s = ST_SEND_CR;
            end
        endcase
    end

    // CR-pending state register; flush or reset abandons a half-sent pair.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            crlf_state_r <= ST_SEND_CR;
        end else if (flush) begin
            crlf_state_r <= ST_SEND_CR;
        end else begin
            crlf_state_r <= crlf_state_nxt_s;
        end
    end

`else

    // Pass-through: every stored byte, including 0x0A, is a single beat.
    assign out_data_s = head_s;
    assign hold_s     = 1'b0;

`endif

endmodule : uart_tx_fifo
